// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the Breakout game-flow controller.
//   - game_state_t : controller states; the encoding is also the LED code
//   - LIVES_DEFAULT / NUM_BRICKS_DEFAULT : default game parameters
//   - BCD_DIGIT_W / BCD_DIGITS : score display geometry
// Optional build macro: PAUSE_EN adds the PAUSED state (code 6).
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int LIVES_DEFAULT      = 3;
    localparam int NUM_BRICKS_DEFAULT = 40;
    localparam int BCD_DIGIT_W        = 4;
    localparam int BCD_DIGITS         = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_MISS     = 3'd3,
        ST_LOST_ALL = 3'd4,
        ST_WON      = 3'd5
`ifdef PAUSE_EN
        ,
        ST_PAUSED   = 3'd6
`endif
    } game_state_t;

endpackage

// File: rtl/bcd_score_counter.sv
// ---------------------------------------------------------------------------
// bcd_score_counter
// Four-digit BCD up-counter that sticks at 9999.
// Ports:
//   clock : system clock
//   reset : asynchronous active-low reset, clears the score
//   en    : increment by one this clock (ignored once at 9999)
//   clr   : synchronous clear, takes priority over en
//   score : registered BCD value, most significant digit in the top nibble
// ---------------------------------------------------------------------------
module bcd_score_counter
    import game_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              clr,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] score
);

    logic [BCD_DIGITS*BCD_DIGIT_W-1:0] score_reg;
    logic [BCD_DIGITS*BCD_DIGIT_W-1:0] score_next;
    logic [BCD_DIGITS:0]               carry;
    logic [BCD_DIGITS-1:0]             is_nine;

    // Ripple carry: a digit advances when every lower digit is rolling over.
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign is_nine[gi]  = (score_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(9));
            assign carry[gi+1]  = carry[gi] & is_nine[gi];
            assign score_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
                !carry[gi]  ? score_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W] :
                is_nine[gi] ? '0 :
                              score_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(1);
        end
    endgenerate

    // carry out of the top digit means every digit is 9: hold instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            score_reg <= '0;
        end else if (clr) begin
            score_reg <= '0;
        end else if (en && !carry[BCD_DIGITS]) begin
            score_reg <= score_next;
        end
    end

    assign score = score_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Game-level sequencer for the Breakout ball datapath: serve hold, play,
// miss handling, lives, brick count, BCD score and speed level.
// Ports:
//   clock       : system clock (pixel clock domain)
//   reset       : asynchronous active-low reset
//   start_btn   : synchronized start button level; its rising edge is a press
//   frame_tick  : one pulse per video frame, paces the serve hold
//   brick_hit   : one brick destroyed (counted only in PLAY)
//   ball_lost   : ball left through the bottom (counted only in PLAY)
//   pause_btn   : (PAUSE_EN only) synchronized pause button level
//   ball_run    : ball mover enable, high only in PLAY
//   ball_reset  : one-cycle pulse on entry to SERVE, re-centres the ball
//   lives       : remaining lives
//   score_bcd   : four BCD digits
//   speed       : speed level for the ball mover
//   state_led   : current state code
//   game_over   : high in LOST_ALL
//   win         : high in WON
// Optional build macro: PAUSE_EN (pause_btn input and PAUSED state).
// ---------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES            = LIVES_DEFAULT,
    parameter int SERVE_TICKS      = 60,
    parameter int NUM_BRICKS       = NUM_BRICKS_DEFAULT,
    parameter int BRICKS_PER_LEVEL = 10,
    parameter int MAX_SPEED        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        frame_tick,
    input  logic        brick_hit,
    input  logic        ball_lost,
`ifdef PAUSE_EN
    input  logic        pause_btn,
`endif
    output logic        ball_run,
    output logic        ball_reset,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic [1:0]  speed,
    output logic [2:0]  state_led,
    output logic        game_over,
    output logic        win
);

    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam int BW = $clog2(NUM_BRICKS + 1);
    localparam int LW = $clog2(BRICKS_PER_LEVEL + 1);

    localparam logic [SW-1:0] SERVE_LAST   = SW'(SERVE_TICKS - 1);
    localparam logic [BW-1:0] BRICKS_INIT  = BW'(NUM_BRICKS);
    localparam logic [LW-1:0] LEVEL_LAST   = LW'(BRICKS_PER_LEVEL - 1);
    localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);
    localparam logic [1:0]    SPEED_TOP    = 2'(MAX_SPEED);

    game_state_t   state_reg;
    logic [SW-1:0] serve_cnt_reg;
    logic [BW-1:0] bricks_left_reg;
    logic [LW-1:0] level_cnt_reg;    // bricks cleared since the last speed step
    logic [1:0]    lives_reg;
    logic [1:0]    speed_reg;
    logic          ball_run_reg;
    logic          ball_reset_reg;
    logic          game_over_reg;
    logic          win_reg;
    logic          start_q_reg;

    logic start_press;
    logic new_game;
    logic score_en;
    logic last_brick;

    assign start_press = start_btn & ~start_q_reg;
    assign new_game    = start_press & ((state_reg == ST_LOST_ALL) || (state_reg == ST_WON));
    assign score_en    = (state_reg == ST_PLAY) & brick_hit;
    assign last_brick  = (bricks_left_reg == BW'(1));

`ifdef PAUSE_EN
    logic pause_q_reg;
    logic pause_press;
    assign pause_press = pause_btn & ~pause_q_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pause_q_reg <= 1'b0;
        end else begin
            pause_q_reg <= pause_btn;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            serve_cnt_reg   <= '0;
            bricks_left_reg <= BRICKS_INIT;
            level_cnt_reg   <= '0;
            lives_reg       <= LIVES_INIT;
            speed_reg       <= '0;
            ball_run_reg    <= 1'b0;
            ball_reset_reg  <= 1'b0;
            game_over_reg   <= 1'b0;
            win_reg         <= 1'b0;
            start_q_reg     <= 1'b0;
        end else begin
            start_q_reg    <= start_btn;
            ball_reset_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start_press) begin
                        state_reg      <= ST_SERVE;
                        serve_cnt_reg  <= '0;
                        ball_reset_reg <= 1'b1;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt_reg == SERVE_LAST) begin
                            state_reg    <= ST_PLAY;
                            ball_run_reg <= 1'b1;
                        end else begin
                            serve_cnt_reg <= serve_cnt_reg + SW'(1);
                        end
                    end
                end

                ST_PLAY: begin
                    // A brick hit in the same cycle as a loss is still counted.
                    if (brick_hit) begin
                        bricks_left_reg <= bricks_left_reg - BW'(1);
                        if (level_cnt_reg == LEVEL_LAST) begin
                            level_cnt_reg <= '0;
                            if (speed_reg < SPEED_TOP) begin
                                speed_reg <= speed_reg + 2'd1;
                            end
                        end else begin
                            level_cnt_reg <= level_cnt_reg + LW'(1);
                        end
                    end

                    if (brick_hit && last_brick) begin
                        state_reg    <= ST_WON;
                        ball_run_reg <= 1'b0;
                        win_reg      <= 1'b1;
                    end else if (ball_lost) begin
                        state_reg    <= ST_MISS;
                        ball_run_reg <= 1'b0;
                    end
`ifdef PAUSE_EN
                    else if (pause_press) begin
                        state_reg    <= ST_PAUSED;
                        ball_run_reg <= 1'b0;
                    end
`endif
                end

                ST_MISS: begin
                    if (lives_reg == 2'd1) begin
                        lives_reg     <= 2'd0;
                        state_reg     <= ST_LOST_ALL;
                        game_over_reg <= 1'b1;
                    end else begin
                        lives_reg      <= lives_reg - 2'd1;
                        state_reg      <= ST_SERVE;
                        serve_cnt_reg  <= '0;
                        ball_reset_reg <= 1'b1;
                    end
                end

                ST_LOST_ALL, ST_WON: begin
                    if (new_game) begin
                        lives_reg       <= LIVES_INIT;
                        speed_reg       <= '0;
                        bricks_left_reg <= BRICKS_INIT;
                        level_cnt_reg   <= '0;
                        game_over_reg   <= 1'b0;
                        win_reg         <= 1'b0;
                        state_reg       <= ST_SERVE;
                        serve_cnt_reg   <= '0;
                        ball_reset_reg  <= 1'b1;
                    end
                end

`ifdef PAUSE_EN
                ST_PAUSED: begin
                    if (pause_press) begin
                        state_reg    <= ST_PLAY;
                        ball_run_reg <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_reg    <= ST_IDLE;
                    ball_run_reg <= 1'b0;
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clock (clock),
        .reset (reset),
        .en    (score_en),
        .clr   (new_game),
        .score (score_bcd)
    );

    assign ball_run   = ball_run_reg;
    assign ball_reset = ball_reset_reg;
    assign lives      = lives_reg;
    assign speed      = speed_reg;
    assign state_led  = state_reg;
    assign game_over  = game_over_reg;
    assign win        = win_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed table, hand-written corner sequences and random stimulus for
// game_flow_ctrl, checked against a game-level reference model. Also drives
// a standalone bcd_score_counter to reach the 9999 ceiling.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

    localparam int LIVES       = 3;
    localparam int SERVE_TICKS = 60;
    localparam int NUM_BRICKS  = 40;
    localparam int PER_LEVEL   = 10;
    localparam int MAX_SPEED   = 3;

    localparam int OP_PRESS   = 0;
    localparam int OP_TICKS   = 1;
    localparam int OP_HITS    = 2;
    localparam int OP_LOST    = 3;
    localparam int OP_HITLOST = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_btn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        brick_hit = 1'b0;
    logic        ball_lost = 1'b0;
    logic        ball_run;
    logic        ball_reset;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [1:0]  speed;
    logic [2:0]  state_led;
    logic        game_over;
    logic        win;

    logic        sc_en = 1'b0;
    logic        sc_clr = 1'b0;
    logic [15:0] sc_score;

    always #5 clock = ~clock;

    game_flow_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start_btn  (start_btn),
        .frame_tick (frame_tick),
        .brick_hit  (brick_hit),
        .ball_lost  (ball_lost),
`ifdef PAUSE_EN
        .pause_btn  (1'b0),
`endif
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .lives      (lives),
        .score_bcd  (score_bcd),
        .speed      (speed),
        .state_led  (state_led),
        .game_over  (game_over),
        .win        (win)
    );

    bcd_score_counter u_sc (
        .clock (clock),
        .reset (reset),
        .en    (sc_en),
        .clr   (sc_clr),
        .score (sc_score)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game-level reference model ----------------
    // m_state holds the LED code of the expected state.
    int m_state, m_lives, m_score, m_cleared, m_serve;
    bit m_start_q, m_ball_reset;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 |
               ((v / 10) % 10) << 4 | (v % 10);
    endfunction

    function automatic int exp_speed();
        int s = m_cleared / PER_LEVEL;
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_score = 0; m_cleared = 0; m_serve = 0;
        m_start_q = 1'b0; m_ball_reset = 1'b0;
    endtask

    task automatic enter_serve();
        m_state = 1; m_serve = 0; m_ball_reset = 1'b1;
    endtask

    task automatic model_step(input bit s, input bit t, input bit h, input bit l);
        bit press = s && !m_start_q;
        m_start_q    = s;
        m_ball_reset = 1'b0;
        case (m_state)
            0: if (press) enter_serve();
            1: if (t) begin
                if (m_serve == SERVE_TICKS - 1) m_state = 2;
                else m_serve++;
            end
            2: begin
                if (h) begin
                    m_cleared++;
                    if (m_score < 9999) m_score++;
                end
                if (h && m_cleared == NUM_BRICKS) m_state = 5;
                else if (l) m_state = 3;
            end
            3: begin
                m_lives--;
                if (m_lives == 0) m_state = 4;
                else enter_serve();
            end
            4, 5: if (press) begin
                m_lives = LIVES; m_score = 0; m_cleared = 0;
                enter_serve();
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state_led"},  int'(state_led),  m_state);
        check({tag, ".ball_run"},   int'(ball_run),   int'(m_state == 2));
        check({tag, ".ball_reset"}, int'(ball_reset), int'(m_ball_reset));
        check({tag, ".lives"},      int'(lives),      m_lives);
        check({tag, ".score_bcd"},  int'(score_bcd),  to_bcd(m_score));
        check({tag, ".speed"},      int'(speed),      exp_speed());
        check({tag, ".game_over"},  int'(game_over),  int'(m_state == 4));
        check({tag, ".win"},        int'(win),        int'(m_state == 5));
    endtask

    // One clock with the given inputs; outputs compared 1 time unit after the edge.
    task automatic cycle(input bit s, input bit t, input bit h, input bit l);
        start_btn = s; frame_tick = t; brick_hit = h; ball_lost = l;
        @(posedge clock);
        model_step(s, t, h, l);
        #1;
        check_outputs("cyc");
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string name;
        int    op;
        int    n;
        int    led;
        int    lives;
        int    score;
        int    speed;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input vec_t v);
        case (v.op)
            OP_PRESS:   begin cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); end
            OP_TICKS:   repeat (v.n) cycle(0, 1, 0, 0);
            OP_HITS:    repeat (v.n) cycle(0, 0, 1, 0);
            OP_LOST:    begin cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); end
            OP_HITLOST: begin cycle(0, 0, 1, 1); cycle(0, 0, 0, 0); end
            default: ;
        endcase
        check({v.name, ".led"},   int'(state_led), v.led);
        check({v.name, ".lives"}, int'(lives),     v.lives);
        check({v.name, ".score"}, int'(score_bcd), v.score);
        check({v.name, ".speed"}, int'(speed),     v.speed);
        $display("vec %-14s led=%0d lives=%0d score=%04h speed=%0d",
                 v.name, state_led, lives, score_bcd, speed);
    endtask

    initial begin
        bit rs;

        vecs.push_back('{"hits12",      OP_HITS,    12, 2, 3, 'h0012, 1});
        vecs.push_back('{"lost1",       OP_LOST,     1, 1, 2, 'h0012, 1});
        vecs.push_back('{"serve2",      OP_TICKS,   60, 2, 2, 'h0012, 1});
        vecs.push_back('{"lost2",       OP_LOST,     1, 1, 1, 'h0012, 1});
        vecs.push_back('{"serve3",      OP_TICKS,   60, 2, 1, 'h0012, 1});
        vecs.push_back('{"lost3",       OP_LOST,     1, 4, 0, 'h0012, 1});
        vecs.push_back('{"dead_hits",   OP_HITS,     2, 4, 0, 'h0012, 1});
        vecs.push_back('{"restart",     OP_PRESS,    1, 1, 3, 'h0000, 0});
        vecs.push_back('{"press_serve", OP_PRESS,    1, 1, 3, 'h0000, 0});
        vecs.push_back('{"serve_g2",    OP_TICKS,   60, 2, 3, 'h0000, 0});
        vecs.push_back('{"hits39",      OP_HITS,    39, 2, 3, 'h0039, 3});
        vecs.push_back('{"hitlost_win", OP_HITLOST,  1, 5, 3, 'h0040, 3});
        vecs.push_back('{"won_hits",    OP_HITS,     3, 5, 3, 'h0040, 3});
        vecs.push_back('{"won_lost",    OP_LOST,     1, 5, 3, 'h0040, 3});
        vecs.push_back('{"won_ticks",   OP_TICKS,    5, 5, 3, 'h0040, 3});
        vecs.push_back('{"restart2",    OP_PRESS,    1, 1, 3, 'h0000, 0});
        vecs.push_back('{"serve_g3",    OP_TICKS,   60, 2, 3, 'h0000, 0});
        vecs.push_back('{"hits4",       OP_HITS,     4, 2, 3, 'h0004, 0});
        vecs.push_back('{"hitlost_miss",OP_HITLOST,  1, 1, 2, 'h0005, 0});
        vecs.push_back('{"reserve",     OP_TICKS,   60, 2, 2, 'h0005, 0});

        // reset values
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset");
        $display("reset: led=%0d lives=%0d score=%04h", state_led, lives, score_bcd);
        reset = 1'b1;

        // serve sequence: ball_reset the cycle after the press, PLAY after tick 60
        cycle(1, 0, 0, 0);
        check("serve.ball_reset_hi", int'(ball_reset), 1);
        cycle(0, 0, 0, 0);
        check("serve.ball_reset_lo", int'(ball_reset), 0);
        repeat (SERVE_TICKS - 1) cycle(0, 1, 0, 0);
        check("serve.tick59_led", int'(state_led), 1);
        check("serve.tick59_run", int'(ball_run), 0);
        cycle(0, 1, 0, 0);
        check("serve.tick60_led", int'(state_led), 2);
        check("serve.tick60_run", int'(ball_run), 1);
        $display("serve: led=%0d ball_run=%0d", state_led, ball_run);

        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset in PLAY with score 5, between clock edges
        #3;
        reset = 1'b0;
        #1;
        check("areset.ball_run", int'(ball_run), 0);
        model_reset();
        check_outputs("areset");
        $display("async reset: ball_run=%0d led=%0d score=%04h", ball_run, state_led, score_bcd);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(0, 0, 0, 0);

        // score ceiling on the standalone counter
        sc_clr = 1'b1;
        @(posedge clock); #1;
        sc_clr = 1'b0;
        sc_en  = 1'b1;
        repeat (1000) @(posedge clock);
        #1;
        check("sat.1000", int'(sc_score), 'h1000);
        repeat (8999) @(posedge clock);
        #1;
        check("sat.9999", int'(sc_score), 'h9999);
        repeat (2) @(posedge clock);
        #1;
        check("sat.hold", int'(sc_score), 'h9999);
        sc_en = 1'b0;
        $display("saturation: score=%04h", sc_score);

        // random play against the reference model
        rs = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(39) == 0) rs = ~rs;
            cycle(rs, $urandom_range(1) == 0, $urandom_range(3) == 0,
                  $urandom_range(39) == 0);
        end
        $display("random: done, led=%0d lives=%0d score=%04h", state_led, lives, score_bcd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
